// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with programmable almost-full/almost-empty thresholds,
// occupancy count, sticky overflow/underflow flags and optional FWFT read port.
module sync_fifo_prog #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 16,
   parameter int FWFT       = 0,
   localparam int ADDR_W    = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_enb,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_enb,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_valid,
   input  logic [ADDR_W:0]       af_level,
   input  logic [ADDR_W:0]       ae_level,
   input  logic                  clr_err,
   output logic [ADDR_W:0]       count,
   output logic                  full,
   output logic                  almost_full,
   output logic                  half_full,
   output logic                  empty,
   output logic                  almost_empty,
   output logic                  overflow,
   output logic                  underflow
);

   localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0] HALF_C  = (ADDR_W+1)'(DEPTH/2);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   logic [ADDR_W:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_W:0] count_q,  count_d;
   logic            overflow_q,  overflow_d;
   logic            underflow_q, underflow_d;
   logic            wr_acc, rd_acc;

   // Flags decode from the registered count; thresholds are live inputs.
   assign count        = count_q;
   assign full         = (count_q == DEPTH_C);
   assign empty        = (count_q == '0);
   assign half_full    = (count_q >= HALF_C);
   assign almost_full  = (count_q >= af_level);
   assign almost_empty = (count_q <= ae_level);
   assign overflow     = overflow_q;
   assign underflow    = underflow_q;

   always_comb begin
      wr_acc      = wr_enb && !full;
      rd_acc      = rd_enb && !empty;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      overflow_d  = overflow_q;
      underflow_d = underflow_q;

      if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;

      case ({wr_acc, rd_acc})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase

      // A new error event in the same cycle as clr_err keeps the flag set.
      if (wr_enb && full)      overflow_d = 1'b1;
      else if (clr_err)        overflow_d = 1'b0;
      if (rd_enb && empty)     underflow_d = 1'b1;
      else if (clr_err)        underflow_d = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_acc) mem_q[wr_ptr_q[ADDR_W-1:0]] <= wr_data;
   end

   generate
      if (FWFT != 0) begin : g_fwft
         assign rd_data  = mem_q[rd_ptr_q[ADDR_W-1:0]];
         assign rd_valid = !empty;
      end else begin : g_std
         logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
         logic                  rd_valid_q, rd_valid_d;

         always_comb begin
            rd_data_d  = rd_data_q;
            rd_valid_d = rd_acc;
            if (rd_acc) rd_data_d = mem_q[rd_ptr_q[ADDR_W-1:0]];
         end

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               rd_data_q  <= '0;
               rd_valid_q <= 1'b0;
            end else begin
               rd_data_q  <= rd_data_d;
               rd_valid_q <= rd_valid_d;
            end
         end

         assign rd_data  = rd_data_q;
         assign rd_valid = rd_valid_q;
      end
   endgenerate

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Bench for sync_fifo_prog: standard-mode instance checked through a read
// scoreboard, FWFT instance checked with directed vectors.
module tb_sync_fifo_prog;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [4:0] af_lvl, ae_lvl;

   logic       rst0, wr0, rd0, clr0;
   logic [7:0] wd0, rdata0;
   logic       rvalid0, full0, afull0, hfull0, empty0, aempty0, ovf0, unf0;
   logic [4:0] count0;

   logic       rst1, wr1, rd1, clr1;
   logic [7:0] wd1, rdata1;
   logic       rvalid1, full1, afull1, hfull1, empty1, aempty1, ovf1, unf1;
   logic [4:0] count1;

   sync_fifo_prog #(.DATA_WIDTH(8), .DEPTH(16), .FWFT(0)) u_std (
      .clk(clk), .rst(rst0), .wr_enb(wr0), .wr_data(wd0), .rd_enb(rd0),
      .rd_data(rdata0), .rd_valid(rvalid0), .af_level(af_lvl), .ae_level(ae_lvl),
      .clr_err(clr0), .count(count0), .full(full0), .almost_full(afull0),
      .half_full(hfull0), .empty(empty0), .almost_empty(aempty0),
      .overflow(ovf0), .underflow(unf0));

   sync_fifo_prog #(.DATA_WIDTH(8), .DEPTH(16), .FWFT(1)) u_fwft (
      .clk(clk), .rst(rst1), .wr_enb(wr1), .wr_data(wd1), .rd_enb(rd1),
      .rd_data(rdata1), .rd_valid(rvalid1), .af_level(af_lvl), .ae_level(ae_lvl),
      .clr_err(clr1), .count(count1), .full(full1), .almost_full(afull1),
      .half_full(hfull1), .empty(empty1), .almost_empty(aempty1),
      .overflow(ovf1), .underflow(unf1));

   typedef struct {
      int         due;
      logic [7:0] data;
   } exp_t;

   exp_t       exp_q[$];
   logic [7:0] mq[$];
   logic       movf = 1'b0, munf = 1'b0;
   int         cyc_cnt = 0;
   int         checks = 0, errors = 0;

   always @(posedge clk) cyc_cnt++;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Read monitor: every accepted read must produce rd_valid with the
   // expected word exactly one cycle later, and rd_valid at no other time.
   always @(negedge clk) begin
      exp_t e;
      if (!rst0) begin
         if (exp_q.size() > 0 && exp_q[0].due == cyc_cnt) begin
            e = exp_q.pop_front();
            chk("rd_valid", {31'd0, rvalid0}, 1);
            chk("rd_data", {24'd0, rdata0}, {24'd0, e.data});
         end else if (rvalid0) begin
            chk("spurious rd_valid", {31'd0, rvalid0}, 0);
         end
      end
   end

   task automatic check_state();
      int n;
      n = mq.size();
      chk("count", {27'd0, count0}, n);
      chk("full", {31'd0, full0}, {31'd0, n == 16});
      chk("empty", {31'd0, empty0}, {31'd0, n == 0});
      chk("half_full", {31'd0, hfull0}, {31'd0, n >= 8});
      chk("almost_full", {31'd0, afull0}, {31'd0, n >= 12});
      chk("almost_empty", {31'd0, aempty0}, {31'd0, n <= 2});
      chk("overflow", {31'd0, ovf0}, {31'd0, movf});
      chk("underflow", {31'd0, unf0}, {31'd0, munf});
   endtask

   // One clock of stimulus on the standard instance; called at a negedge.
   task automatic op(input logic w, input logic [7:0] d, input logic r, input logic c);
      logic mfull, mempty;
      exp_t e;
      mfull  = (mq.size() == 16);
      mempty = (mq.size() == 0);
      wr0 = w; wd0 = d; rd0 = r; clr0 = c;
      if (r && !mempty) begin
         e.due  = cyc_cnt + 1;
         e.data = mq.pop_front();
         exp_q.push_back(e);
      end
      if (w && !mfull) mq.push_back(d);
      movf = (w && mfull)  ? 1'b1 : (c ? 1'b0 : movf);
      munf = (r && mempty) ? 1'b1 : (c ? 1'b0 : munf);
      @(posedge clk);
      @(negedge clk);
      wr0 = 1'b0; rd0 = 1'b0; clr0 = 1'b0;
      check_state();
   endtask

   task automatic cyc1();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      rst0 = 1'b1; rst1 = 1'b1;
      wr0 = 0; rd0 = 0; clr0 = 0; wd0 = 0;
      wr1 = 0; rd1 = 0; clr1 = 0; wd1 = 0;
      af_lvl = 5'd0; ae_lvl = 5'd2;
      #1 chk("almost_full af_level=0", {31'd0, afull0}, 1);
      af_lvl = 5'd12;
      #1 chk("almost_full af_level=12", {31'd0, afull0}, 0);
      repeat (3) @(negedge clk);
      chk("reset count", {27'd0, count0}, 0);
      chk("reset empty", {31'd0, empty0}, 1);
      chk("reset almost_empty", {31'd0, aempty0}, 1);
      chk("reset full", {31'd0, full0}, 0);
      chk("reset half_full", {31'd0, hfull0}, 0);
      chk("reset overflow", {31'd0, ovf0}, 0);
      chk("reset rd_valid", {31'd0, rvalid0}, 0);
      rst0 = 1'b0;

      // Fill 0x00..0x0F with hand-placed threshold crossings
      for (int i = 0; i < 16; i++) begin
         op(1'b1, 8'(i), 1'b0, 1'b0);
         if (i == 1)  chk("almost_empty at 2", {31'd0, aempty0}, 1);
         if (i == 2)  chk("almost_empty at 3", {31'd0, aempty0}, 0);
         if (i == 7)  chk("half_full at 8", {31'd0, hfull0}, 1);
         if (i == 11) chk("almost_full at 12", {31'd0, afull0}, 1);
         if (i == 15) chk("full at 16", {31'd0, full0}, 1);
      end
      op(1'b1, 8'hEE, 1'b0, 1'b0);
      chk("overflow on 17th write", {31'd0, ovf0}, 1);
      chk("count held at 16", {27'd0, count0}, 16);
      for (int i = 0; i < 16; i++) op(1'b0, 8'h00, 1'b1, 1'b0);
      chk("empty after drain", {31'd0, empty0}, 1);
      op(1'b0, 8'h00, 1'b1, 1'b0);
      chk("underflow on empty read", {31'd0, unf0}, 1);
      op(1'b0, 8'h00, 1'b0, 1'b1);
      chk("overflow cleared", {31'd0, ovf0}, 0);
      chk("underflow cleared", {31'd0, unf0}, 0);

      for (int i = 0; i < 16; i++) op(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
      op(1'b1, 8'h77, 1'b0, 1'b1);
      chk("set wins over clr_err", {31'd0, ovf0}, 1);
      op(1'b0, 8'h00, 1'b0, 1'b1);
      op(1'b1, 8'h99, 1'b1, 1'b0);
      chk("simultaneous at full count", {27'd0, count0}, 15);
      for (int i = 0; i < 15; i++) op(1'b0, 8'h00, 1'b1, 1'b0);
      op(1'b0, 8'h00, 1'b0, 1'b1);

      // Streaming at half occupancy
      for (int i = 0; i < 8; i++) op(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
      for (int k = 0; k < 20; k++) op(1'b1, 8'(8'h28 + k), 1'b1, 1'b0);
      chk("count stays 8", {27'd0, count0}, 8);
      for (int i = 0; i < 8; i++) op(1'b0, 8'h00, 1'b1, 1'b0);

      // Pointer wrap with alternating patterns
      for (int i = 0; i < 5; i++) op(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
      for (int k = 0; k < 40; k++) op(1'b1, (k % 2 == 1) ? 8'h5A : 8'hA5, 1'b1, 1'b0);
      chk("count stays 5", {27'd0, count0}, 5);
      for (int i = 0; i < 5; i++) op(1'b0, 8'h00, 1'b1, 1'b0);
      repeat (3) op(1'b0, 8'h00, 1'b0, 1'b0);
      chk("scoreboard drained", exp_q.size(), 0);

      // FWFT instance
      rst1 = 1'b0;
      wr1 = 1'b1; wd1 = 8'h3C;
      cyc1();
      wr1 = 1'b0;
      chk("fwft first rd_valid", {31'd0, rvalid1}, 1);
      chk("fwft first rd_data", {24'd0, rdata1}, 8'h3C);
      chk("fwft count 1", {27'd0, count1}, 1);
      rd1 = 1'b1;
      cyc1();
      rd1 = 1'b0;
      chk("fwft rd_valid after pop", {31'd0, rvalid1}, 0);
      chk("fwft empty after pop", {31'd0, empty1}, 1);
      for (int i = 0; i < 6; i++) begin
         wr1 = 1'b1; wd1 = 8'(8'h60 + i);
         cyc1();
      end
      wr1 = 1'b0;
      chk("fwft head 0x60", {24'd0, rdata1}, 8'h60);
      chk("fwft count 6", {27'd0, count1}, 6);
      rd1 = 1'b1;
      cyc1();
      rd1 = 1'b0;
      chk("fwft head 0x61", {24'd0, rdata1}, 8'h61);
      chk("fwft count 5", {27'd0, count1}, 5);
      wr1 = 1'b1; wd1 = 8'h66;
      cyc1();
      wr1 = 1'b0;
      chk("fwft count back to 6", {27'd0, count1}, 6);
      #2 rst1 = 1'b1;
      #1;
      chk("async reset count", {27'd0, count1}, 0);
      chk("async reset rd_valid", {31'd0, rvalid1}, 0);
      chk("async reset empty", {31'd0, empty1}, 1);
      @(negedge clk);
      rst1 = 1'b0;
      rd1 = 1'b1;
      cyc1();
      rd1 = 1'b0;
      chk("post-reset read sees empty", {31'd0, unf1}, 1);
      chk("post-reset count", {27'd0, count1}, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
